// File: rtl/somador_serial.sv
// somador_serial: digit-serial N-bit add/subtract, K bits per cycle through one registered carry
// ports: clk, rst_n (async, active-low); start/sub/A/B/Cin request, sampled when busy == 0;
//        busy, done (one-cycle pulse), S, Cout (1 = no borrow on sub) and ovf (signed overflow)
module somador_serial #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         ovf
);
    localparam int D  = N / K;
    localparam int CW = $clog2(D + 1);

    if (N < 2 || K < 1 || K > N || N % K != 0) begin : g_bad_params
        $error("somador_serial: need N >= 2, 1 <= K <= N and N divisible by K");
    end

    typedef enum logic [1:0] {OCIOSO, SOMANDO, PRONTO} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_r, b_r, w_r, w_nx;
    logic           c_r, c_msb, accept, last;
    logic [CW-1:0]  cnt;
    logic [K:0]     dsum;

    assign dsum   = (K+1)'(a_r[K-1:0]) + (K+1)'(b_r[K-1:0]) + (K+1)'(c_r);
    // carry into the top bit of the digit recovered from that bit's sum: c = s ^ a ^ b
    assign c_msb  = a_r[K-1] ^ b_r[K-1] ^ dsum[K-1];
    assign w_nx   = (w_r >> K) | (N'(dsum[K-1:0]) << (N - K));
    assign accept = start && state != SOMANDO;
    assign last   = state == SOMANDO && cnt == CW'(D - 1);
    assign busy   = state == SOMANDO;
    assign done   = state == PRONTO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OCIOSO;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == SOMANDO) state_nx = last ? PRONTO : SOMANDO;
        else                  state_nx = start ? SOMANDO : OCIOSO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            w_r  <= '0;
            c_r  <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_r <= A;
            b_r <= sub ? ~B : B;
            c_r <= sub | Cin;
            cnt <= '0;
            w_r <= '0;
        end else if (state == SOMANDO) begin
            a_r <= a_r >> K;
            b_r <= b_r >> K;
            c_r <= dsum[K];
            cnt <= cnt + 1'b1;
            w_r <= w_nx;
            if (last) begin
                S    <= w_nx;
                Cout <= dsum[K];
                ovf  <= dsum[K] ^ c_msb;
            end
        end
    end
endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: directed and exhaustive checks of somador_serial for several N/K
module tb_somador_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sub = 1'b0, Cin = 1'b0, st4 = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic [2:0] st = '0, busy8, done8, c8, v8, busy4, done4, c4, v4;
    logic [7:0] s8 [3];
    logic [3:0] s4 [3];
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g8
        localparam int KK = (g == 0) ? 1 : (g == 1) ? 4 : 2;
        somador_serial #(.N(8), .K(KK)) u (
            .clk(clk), .rst_n(rst_n), .start(st[g]), .sub(sub), .A(A), .B(B), .Cin(Cin),
            .busy(busy8[g]), .done(done8[g]), .S(s8[g]), .Cout(c8[g]), .ovf(v8[g])
        );
    end

    for (genvar g = 0; g < 3; g++) begin : g4
        localparam int KK = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        somador_serial #(.N(4), .K(KK)) u (
            .clk(clk), .rst_n(rst_n), .start(st4), .sub(sub), .A(A[3:0]), .B(B[3:0]), .Cin(Cin),
            .busy(busy4[g]), .done(done4[g]), .S(s4[g]), .Cout(c4[g]), .ovf(v4[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 1;
        while (!done8[i] && lat < 40) begin
            @(negedge clk);
            if (!done8[i]) lat++;
        end
    endtask

    task automatic op(input string tag, input int i, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input logic c, input int exp_lat,
                      input logic [7:0] es, input logic ec, input logic ev);
        int lat;
        sub = s; A = a; B = b; Cin = c; st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
        chk({tag, " busy"}, 32'(busy8[i]), 32'd1);
        wait_done(i, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " S"}, 32'(s8[i]), 32'(es));
        chk({tag, " Cout"}, 32'(c8[i]), 32'(ec));
        chk({tag, " ovf"}, 32'(v8[i]), 32'(ev));
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done8[i]), 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [4:0] r;
        logic [3:0] a4, b4;
        logic rv;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'({busy8, busy4}), 32'd0);
        chk("reset done", 32'({done8, done4}), 32'd0);
        chk("reset S", 32'(s8[0]), 32'd0);
        chk("reset flags", 32'({c8, v8}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op("k1 0f+01", 0, 1'b0, 8'h0F, 8'h01, 1'b0, 8, 8'h10, 1'b0, 1'b0);
        op("k4 7f+01", 1, 1'b0, 8'h7F, 8'h01, 1'b0, 2, 8'h80, 1'b0, 1'b1);
        op("k4 ff+01+1", 1, 1'b0, 8'hFF, 8'h01, 1'b1, 2, 8'h01, 1'b1, 1'b0);
        op("k2 05-07", 2, 1'b1, 8'h05, 8'h07, 1'b1, 4, 8'hFE, 1'b0, 1'b0);
        op("k2 80-01", 2, 1'b1, 8'h80, 8'h01, 1'b0, 4, 8'h7F, 1'b1, 1'b1);

        // start kept high through SOMANDO and PRONTO with operands changing
        sub = 1'b0; A = 8'h21; B = 8'h12; Cin = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        A = 8'hFF; B = 8'hFF;
        wait_done(0, lat);
        chk("hs first latency", 32'(lat), 32'd8);
        chk("hs first S", 32'(s8[0]), 32'h33);
        @(negedge clk);
        st[0] = 1'b0;
        chk("hs b2b busy", 32'(busy8[0]), 32'd1);
        chk("hs b2b done", 32'(done8[0]), 32'd0);
        chk("hs S held", 32'(s8[0]), 32'h33);
        wait_done(0, lat);
        chk("hs second latency", 32'(lat), 32'd8);
        chk("hs second S", 32'(s8[0]), 32'hFE);
        chk("hs second flags", 32'({c8[0], v8[0]}), 32'b10);
        @(negedge clk);

        // asynchronous reset in the middle of a K=1 operation
        A = 8'h55; B = 8'h11; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy8[0]), 32'd0);
        chk("async rst S", 32'({s8[0], s8[1]}), 32'd0);
        chk("async rst flags", 32'({c8, v8, done8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | done8[0] | busy8[0];
        end
        chk("no done after rst", 32'(seen), 32'd0);
        op("k1 03+04 after rst", 0, 1'b0, 8'h03, 8'h04, 1'b0, 8, 8'h07, 1'b0, 1'b0);

        // exhaustive N=4 against a behavioural reference
        for (int sb = 0; sb < 2; sb++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++) begin
                        a4 = 4'(a); b4 = 4'(b);
                        sub = 1'(sb); A = {4'h0, a4}; B = {4'h0, b4}; Cin = 1'(c);
                        r = sb != 0 ? {1'b0, a4} + {1'b0, ~b4} + 5'd1 : {1'b0, a4} + {1'b0, b4} + 5'(c);
                        rv = sb != 0 ? (a4[3] != b4[3] && r[3] != a4[3]) : (a4[3] == b4[3] && r[3] != a4[3]);
                        st4 = 1'b1;
                        @(negedge clk);
                        st4 = 1'b0;
                        lat = 1;
                        while (!done4[0] && lat < 20) begin
                            @(negedge clk);
                            lat++;
                        end
                        for (int k = 0; k < 3; k++) begin
                            chk($sformatf("n4 k%0d S %0d %0h %0h %0d", k, sb, a, b, c), 32'(s4[k]), 32'(r[3:0]));
                            chk($sformatf("n4 k%0d Cout %0d %0h %0h %0d", k, sb, a, b, c), 32'(c4[k]), 32'(r[4]));
                            chk($sformatf("n4 k%0d ovf %0d %0h %0h %0d", k, sb, a, b, c), 32'(v4[k]), 32'(rv));
                        end
                        @(negedge clk);
                    end
        $display("Teste finalizado!");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/somador_serial.md
Name: somador_serial

Overview:
- Parametrised, digit-serial successor to the single-bit full adder.
- Adds or subtracts two N-bit operands over N/K clock cycles, processing K bits per cycle through one registered carry.
- Uses a start/busy/done handshake, holds its result between operations and flags signed overflow.
- Intended as the shared arithmetic unit for the multi-bit datapath exercises that follow.

Parameters:
- N, 8, operand/result width in bits; N >= 2.
- K, 1, bits processed per cycle; 1 <= K <= N and N mod K == 0 (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy == 0.
- sub  input  1  0 = A + B + Cin; 1 = A - B (B inverted, carry-in forced to 1, Cin ignored).
- A  input  N  operand A, captured when start is accepted.
- B  input  N  operand B, captured when start is accepted.
- Cin  input  1  carry-in for addition, captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S/Cout/ovf are updated.
- S  output  N  result (mod 2^N); stable between done pulses.
- Cout  output  1  carry-out of the MSB; for subtraction 1 = no borrow (A >= B unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-operation): state OCIOSO; busy=0, done=0, S=0, Cout=0, ovf=0; internal shift registers, carry and digit counter cleared. The in-flight operation is discarded and no done is produced.
- FSM states: OCIOSO, SOMANDO, PRONTO.
- OCIOSO: busy=0. start=1 at a rising edge: load A, B (inverted if sub), carry=(sub ? 1 : Cin), counter=0, working sum register=0; go to SOMANDO.
- SOMANDO: busy=1.
  - Each edge adds the low K bits of A, B and the carry.
  - The K-bit sum shifts into the top of the working register; A and B shift right by K; the carry register updates; the counter increments.
  - On the edge completing digit N/K-1: copy the working register to S, set Cout, set ovf, pulse done=1, go to PRONTO.
  - start is ignored while in SOMANDO.
- PRONTO: busy=0, done=1 for exactly this cycle.
  - start=1 at the next edge: accept a new operation (load as in OCIOSO, go to SOMANDO, done drops).
  - Otherwise go to OCIOSO, done drops.
- Latency: done is high in the cycle after the N/K-th rising edge following the edge that accepted start. Example: N=8, K=1 gives 8 cycles; N=8, K=4 gives 2 cycles.
- Throughput: back-to-back operations are accepted with no idle cycle; one result per N/K+1 cycles.
- S, Cout and ovf change only at the completion edge or reset. They hold their value through OCIOSO and through a following SOMANDO.
- The carry into the MSB is taken from the bit-(K-1) stage of the final digit; for K=1 it is the carry register value entering the last cycle.
- Operand inputs may change freely after the accepting edge without affecting the result.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Parameter sweep: N=8, K=1, A=8'h0F, B=8'h01, Cin=0, sub=0, start pulse -> busy high 8 cycles, done pulses once, S=8'h10, Cout=0, ovf=0.
- Wrap and signed overflow: N=8, K=4, A=8'h7F, B=8'h01, Cin=0 -> done after 2 cycles, S=8'h80, Cout=0, ovf=1. Then A=8'hFF, B=8'h01, Cin=1 -> S=8'h01, Cout=1, ovf=0.
- Subtraction: N=8, K=2, sub=1, A=8'h05, B=8'h07, Cin=1 (must be ignored) -> S=8'hFE, Cout=0 (borrow), ovf=0. Then A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, ovf=1.
- Handshake: start re-asserted and A/B changed during SOMANDO -> ignored, result matches the first operands. start held high across PRONTO -> second operation begins with no idle cycle, S holds the first result until the second done.
- Reset mid-operation: N=8, K=1, assert rst_n=0 asynchronously (between edges) at cycle 4 of 8 -> all outputs 0 immediately, no done. After release, a new operation A=8'h03, B=8'h04 gives S=8'h07 after 8 cycles.
- Exhaustive self-check: N=4, K in {1,2,4}, all A, B, Cin, sub combinations compared against a behavioural reference for S, Cout and ovf; the bench prints "Teste finalizado!" on completion.
